// File: rtl/vc_pop_arbiter_if.sv
// Bundle of VC FIFO heads, destination flow control and the merged output stream.
// master = the arbiter, slave = the FIFO/demux environment around it.
interface vc_pop_arbiter_if #(
   parameter int unsigned DATA_WIDTH = 6
);
   logic [DATA_WIDTH-1:0] vc0_data;
   logic                  vc0_empty;
   logic [DATA_WIDTH-1:0] vc1_data;
   logic                  vc1_empty;
   logic                  d0_almost_full;
   logic                  d1_almost_full;
   logic                  vc0_pop;
   logic                  vc1_pop;
   logic [DATA_WIDTH-1:0] data_out;
   logic                  valid_out;
   logic                  src_vc;

   modport master (
      input  vc0_data, vc0_empty, vc1_data, vc1_empty, d0_almost_full, d1_almost_full,
      output vc0_pop, vc1_pop, data_out, valid_out, src_vc
   );

   modport slave (
      output vc0_data, vc0_empty, vc1_data, vc1_empty, d0_almost_full, d1_almost_full,
      input  vc0_pop, vc1_pop, data_out, valid_out, src_vc
   );
endinterface

// File: rtl/vc_pop_arbiter.sv
// Merges VC0/VC1 FIFO heads into one registered stream; VC0 has priority, with a
// burst limiter bounding VC1 starvation and per-destination almost-full gating.
module vc_pop_arbiter #(
   parameter int unsigned DATA_WIDTH    = 6,
   parameter int unsigned DEST_BIT      = 4,
   parameter int unsigned MAX_VC0_BURST = 3
) (
   input logic              clk,
   input logic              reset,
   vc_pop_arbiter_if.master bus
);
   localparam logic [3:0] MaxBurst = 4'(MAX_VC0_BURST);

   logic                  af0, af1, elig0, elig1, grant0, grant1;
   logic [3:0]            streak_q, streak_d;
   logic [DATA_WIDTH-1:0] data_q;
   logic                  valid_q, src_q;

   always_comb begin
      af0    = bus.vc0_data[DEST_BIT] ? bus.d1_almost_full : bus.d0_almost_full;
      af1    = bus.vc1_data[DEST_BIT] ? bus.d1_almost_full : bus.d0_almost_full;
      elig0  = !bus.vc0_empty && !af0;
      elig1  = !bus.vc1_empty && !af1;
      // Reset suppresses pops so FIFO contents survive a mid-stream reset.
      grant0 = !reset && elig0 && (!elig1 || (streak_q < MaxBurst));
      grant1 = !reset && elig1 && !grant0;
   end

   always_comb begin
      streak_d = streak_q;
      if (grant1) begin
         streak_d = 4'd0;
      end else if (grant0) begin
         if (!elig1) streak_d = 4'd0;
         else if (streak_q >= MaxBurst) streak_d = MaxBurst;
         else streak_d = streak_q + 4'd1;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         streak_q <= 4'd0;
         data_q   <= '0;
         valid_q  <= 1'b0;
         src_q    <= 1'b0;
      end else begin
         streak_q <= streak_d;
         valid_q  <= grant0 || grant1;
         if (grant0) begin
            data_q <= bus.vc0_data;
            src_q  <= 1'b0;
         end else if (grant1) begin
            data_q <= bus.vc1_data;
            src_q  <= 1'b1;
         end else begin
            data_q <= '0;
         end
      end
   end

   assign bus.vc0_pop   = grant0;
   assign bus.vc1_pop   = grant1;
   assign bus.data_out  = data_q;
   assign bus.valid_out = valid_q;
   assign bus.src_vc    = src_q;
endmodule
